wfg_stim_ramp: RTL and testbench

// - Ramp stimulus source: generates unsigned sawtooth or triangle sample sequences.
// - Emits them on an AXI-Stream master, one sample per accepted beat.
// - Sits directly upstream of a wfg drive stage (e.g. the SPI driver) and feeds its AXI-Stream slave input.
// - Config comes from the block's wishbone register file; this core has no bus logic.

---
 rtl/wfg_stim_ramp_pkg.sv | 15 +
 rtl/wfg_stim_ramp_step.sv | 63 ++++++
 rtl/wfg_stim_ramp.sv | 117 +++++++++++
 tb/tb_wfg_stim_ramp.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wfg_stim_ramp_pkg.sv
// Shared types for the ramp stimulus source.
// State encoding and waveform mode selectors.
package wfg_stim_ramp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    DRAIN
  } state_t;

  localparam logic MODE_SAW = 1'b0;
  localparam logic MODE_TRI = 1'b1;

endpackage

// File: rtl/wfg_stim_ramp_step.sv
// Combinational next-sample calculator for the ramp source.
// Uses one extra bit for sums and compares so nothing wraps.
module wfg_stim_ramp_step
  import wfg_stim_ramp_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] v,
  input  logic [W-1:0] inc,
  input  logic [W-1:0] start,
  input  logic [W-1:0] lim,
  input  logic         mode,
  input  logic         dir,
  output logic [W-1:0] next_v,
  output logic         next_dir
);

  logic [W:0] sum;
  logic [W:0] floor_v;
  logic       flat;
  logic       is_saw;
  logic       is_up;
  logic       is_dn;

  assign sum     = {1'b0, v} + {1'b0, inc};
  assign floor_v = {1'b0, start} + {1'b0, inc};
  assign flat    = (inc == '0) || (start >= lim);
  assign is_saw  = !flat && (mode == MODE_SAW);
  assign is_up   = !flat && (mode == MODE_TRI) && !dir;
  assign is_dn   = !flat && (mode == MODE_TRI) && dir;

  always_comb begin
    next_v   = start;
    next_dir = 1'b0;
    unique case (1'b1)
      is_saw: begin
        if (sum > {1'b0, lim}) next_v = start;
        else                   next_v = sum[W-1:0];
      end
      is_up: begin
        if (sum >= {1'b0, lim}) begin
          next_v   = lim;
          next_dir = 1'b1;
        end else begin
          next_v = sum[W-1:0];
        end
      end
      is_dn: begin
        if ({1'b0, v} <= floor_v) begin
          next_v = start;
        end else begin
          next_v   = v - inc;
          next_dir = 1'b1;
        end
      end
      default: begin
        next_v   = start;
        next_dir = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wfg_stim_ramp.sv
// Ramp stimulus source: sawtooth/triangle samples on AXI-Stream.
// FSM, shadow config, frame counter and output register.
module wfg_stim_ramp
  import wfg_stim_ramp_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FRAME_W         = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       ctrl_en_q_i,
  input  logic                       cfg_mode_q_i,
  input  logic [AXIS_DATA_WIDTH-1:0] cfg_start_q_i,
  input  logic [AXIS_DATA_WIDTH-1:0] cfg_inc_q_i,
  input  logic [AXIS_DATA_WIDTH-1:0] cfg_limit_q_i,
  input  logic [FRAME_W-1:0]         cfg_len_q_i,
  input  logic                       wfg_axis_tready_i,
  output logic                       wfg_axis_tvalid_o,
  output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
  output logic                       wfg_axis_tlast_o,
  output logic                       busy_o
);

  localparam logic [FRAME_W-1:0] ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

  state_t                     state;
  logic [AXIS_DATA_WIDTH-1:0] start_q;
  logic [AXIS_DATA_WIDTH-1:0] inc_q;
  logic [AXIS_DATA_WIDTH-1:0] lim_q;
  logic                       mode_q;
  logic [FRAME_W-1:0]         len_q;
  logic [FRAME_W-1:0]         cnt_q;

  logic                       beat;
  logic [AXIS_DATA_WIDTH-1:0] next_v;
  logic                       next_dir;
  logic [FRAME_W-1:0]         cnt_nxt;
  logic                       tlast_nxt;
  logic [AXIS_DATA_WIDTH-1:0] lim_eff;

  assign beat      = wfg_axis_tvalid_o & wfg_axis_tready_i;
  assign busy_o    = (state != IDLE);
  assign cnt_nxt   = wfg_axis_tlast_o ? '0 : cnt_q + ONE;
  assign tlast_nxt = (len_q != '0) && (cnt_nxt == len_q - ONE);
  assign lim_eff   = (cfg_limit_q_i > cfg_start_q_i) ?
                     cfg_limit_q_i : cfg_start_q_i;

  wfg_stim_ramp_step #(
    .W (AXIS_DATA_WIDTH)
  ) u_step (
    .v        (wfg_axis_tdata_o),
    .inc      (inc_q),
    .start    (start_q),
    .lim      (lim_q),
    .mode     (mode_q),
    .dir      (state == DOWN),
    .next_v   (next_v),
    .next_dir (next_dir)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state             <= IDLE;
      start_q           <= '0;
      inc_q             <= '0;
      lim_q             <= '0;
      mode_q            <= MODE_SAW;
      len_q             <= '0;
      cnt_q             <= '0;
      wfg_axis_tvalid_o <= 1'b0;
      wfg_axis_tdata_o  <= '0;
      wfg_axis_tlast_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctrl_en_q_i) begin
            start_q           <= cfg_start_q_i;
            inc_q             <= cfg_inc_q_i;
            lim_q             <= lim_eff;
            mode_q            <= cfg_mode_q_i;
            len_q             <= cfg_len_q_i;
            cnt_q             <= '0;
            wfg_axis_tvalid_o <= 1'b1;
            wfg_axis_tdata_o  <= cfg_start_q_i;
            wfg_axis_tlast_o  <= (cfg_len_q_i == ONE);
            state             <= UP;
          end
        end
        UP, DOWN: begin
          if (!ctrl_en_q_i) begin
            if (beat) begin
              wfg_axis_tvalid_o <= 1'b0;
              wfg_axis_tlast_o  <= 1'b0;
              state             <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (beat) begin
            wfg_axis_tdata_o <= next_v;
            wfg_axis_tlast_o <= tlast_nxt;
            cnt_q            <= cnt_nxt;
            state            <= next_dir ? DOWN : UP;
          end
        end
        DRAIN: begin
          if (beat) begin
            wfg_axis_tvalid_o <= 1'b0;
            wfg_axis_tlast_o  <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wfg_stim_ramp.sv
// Self-checking bench for wfg_stim_ramp.
// Expected samples come from a per-period list built from the ramp rules.
module tb_wfg_stim_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [31:0] start;
  logic [31:0] inc;
  logic [31:0] limit;
  logic [15:0] len;
  logic        tready;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  longint      per_q[$];
  int          bidx;
  logic [15:0] cur_len;

  always #5 clk = ~clk;

  wfg_stim_ramp #(
    .AXIS_DATA_WIDTH (32),
    .FRAME_W         (16)
  ) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (rst),
    .ctrl_en_q_i       (en),
    .cfg_mode_q_i      (mode),
    .cfg_start_q_i     (start),
    .cfg_inc_q_i       (inc),
    .cfg_limit_q_i     (limit),
    .cfg_len_q_i       (len),
    .wfg_axis_tready_i (tready),
    .wfg_axis_tvalid_o (tvalid),
    .wfg_axis_tdata_o  (tdata),
    .wfg_axis_tlast_o  (tlast),
    .busy_o            (busy)
  );

  // One full period of the waveform, using 64-bit arithmetic.
  function automatic void build(input longint s, input longint i,
                                input longint l, input bit m);
    longint lim;
    lim = (l > s) ? l : s;
    per_q.delete();
    if (i == 0 || s >= lim) begin
      per_q.push_back(s);
    end else if (!m) begin
      for (longint v = s; v <= lim; v += i) per_q.push_back(v);
    end else begin
      for (longint v = s; v < lim; v += i) per_q.push_back(v);
      per_q.push_back(lim);
      for (longint v = lim - i; v > s; v -= i) per_q.push_back(v);
    end
  endfunction

  function automatic logic [31:0] exp_data(input int k);
    return 32'(per_q[k % per_q.size()]);
  endfunction

  function automatic logic exp_last(input int k);
    if (cur_len == 0) return 1'b0;
    return (k % int'(cur_len)) == int'(cur_len) - 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (tvalid !== 1'b0 || tdata !== 32'd0 ||
        tlast !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: v=%b d=%h l=%b b=%b want 0/0/0/0",
               tvalid, tdata, tlast, busy);
    end
  endtask

  task automatic start_run(input logic [31:0] s, input logic [31:0] i,
                           input logic [31:0] l, input bit m,
                           input logic [15:0] ln);
    @(negedge clk);
    start = s; inc = i; limit = l; mode = m; len = ln;
    en = 1'b1; tready = 1'b0;
    build(longint'(s), longint'(i), longint'(l), m);
    bidx = 0;
    cur_len = ln;
    n_cmp++;
    if (tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_enable_tvalid: got %b want 0", tvalid);
    end
    @(negedge clk);
    n_cmp++;
    if (tvalid !== 1'b1 || tdata !== s || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL enable_latency: v=%b d=%h b=%b want 1/%h/1",
               tvalid, tdata, busy, s);
    end
  endtask

  task automatic stream(input int n, input int low_pct);
    int          got = 0;
    int          cyc = 0;
    logic        held = 1'b0;
    logic [31:0] hd = '0;
    logic        hl = 1'b0;
    while (got < n && cyc < 4000) begin
      if (held) begin
        n_cmp++;
        if (tvalid !== 1'b1 || tdata !== hd || tlast !== hl) begin
          n_bad++;
          $display("FAIL stall_hold: v=%b d=%h l=%b want 1/%h/%b",
                   tvalid, tdata, tlast, hd, hl);
        end
      end
      tready = ($urandom_range(99) >= low_pct);
      if (tvalid && tready) begin
        n_cmp++;
        if (tdata !== exp_data(bidx) || tlast !== exp_last(bidx)) begin
          n_bad++;
          $display("FAIL beat[%0d]: d=%h l=%b want %h/%b", bidx,
                   tdata, tlast, exp_data(bidx), exp_last(bidx));
        end
        bidx++;
        got++;
        held = 1'b0;
      end else begin
        held = tvalid;
        hd   = tdata;
        hl   = tlast;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_timeout: got %0d beats want %0d", got, n);
    end
  endtask

  task automatic stop_with_beat();
    tready = 1'b1;
    en = 1'b0;
    n_cmp++;
    if (tvalid !== 1'b1 || tdata !== exp_data(bidx)) begin
      n_bad++;
      $display("FAIL stop_beat: v=%b d=%h want 1/%h",
               tvalid, tdata, exp_data(bidx));
    end
    @(negedge clk);
    tready = 1'b0;
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_idle: v=%b b=%b want 0/0", tvalid, busy);
    end
  endtask

  task automatic test_sawtooth();
    start_run(32'd0, 32'd3, 32'd10, 1'b0, 16'd0);
    stream(10, 0);
    stop_with_beat();
  endtask

  task automatic test_triangle();
    start_run(32'd0, 32'd3, 32'd10, 1'b1, 16'd0);
    stream(20, 0);
    stop_with_beat();
  endtask

  task automatic test_backpressure();
    start_run(32'd0, 32'd3, 32'd10, 1'b1, 16'd4);
    stream(40, 30);
    stop_with_beat();
    start_run(32'd0, 32'd3, 32'd10, 1'b0, 16'd3);
    stream(30, 30);
    stop_with_beat();
  endtask

  task automatic test_frames();
    start_run(32'd1, 32'd2, 32'd9, 1'b0, 16'd4);
    stream(12, 0);
    stop_with_beat();
    start_run(32'd1, 32'd2, 32'd9, 1'b0, 16'd0);
    stream(12, 0);
    stop_with_beat();
    start_run(32'd1, 32'd2, 32'd9, 1'b1, 16'd1);
    stream(12, 20);
    stop_with_beat();
  endtask

  task automatic test_drain();
    logic [31:0] d;
    start_run(32'd5, 32'd2, 32'd30, 1'b0, 16'd3);
    stream(5, 30);
    tready = 1'b0;
    en = 1'b0;
    d = tdata;
    @(negedge clk);
    n_cmp++;
    if (tvalid !== 1'b1 || tdata !== d || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_hold: v=%b d=%h b=%b want 1/%h/1",
               tvalid, tdata, busy, d);
    end
    start = 32'd77; inc = 32'd1; limit = 32'd90;
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tvalid !== 1'b1 || tdata !== exp_data(bidx)) begin
      n_bad++;
      $display("FAIL drain_reenable: v=%b d=%h want 1/%h",
               tvalid, tdata, exp_data(bidx));
    end
    tready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_off: v=%b want 0", tvalid);
    end
    @(negedge clk);
    n_cmp++;
    if (tvalid !== 1'b1 || tdata !== 32'd77) begin
      n_bad++;
      $display("FAIL drain_new_cfg: v=%b d=%h want 1/%h",
               tvalid, tdata, 32'd77);
    end
    do_reset();
  endtask

  task automatic test_reset_midrun();
    start_run(32'd4, 32'd5, 32'd50, 1'b1, 16'd2);
    stream(6, 0);
    tready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tvalid !== 1'b1) begin
      n_bad++;
      $display("FAIL midrun_pre: v=%b want 1", tvalid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    n_cmp++;
    if (tvalid !== 1'b0 || tdata !== 32'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_reset: v=%b d=%h b=%b want 0/0/0",
               tvalid, tdata, busy);
    end
  endtask

  task automatic test_edges();
    start_run(32'd7, 32'd0, 32'd40, 1'b1, 16'd0);
    stream(6, 20);
    stop_with_beat();
    start_run(32'd20, 32'd3, 32'd10, 1'b0, 16'd0);
    stream(6, 20);
    stop_with_beat();
    start_run(32'd20, 32'd3, 32'd10, 1'b1, 16'd0);
    stream(6, 20);
    stop_with_beat();
    start_run(32'd0, 32'hFFFF_FFFF, 32'd10, 1'b0, 16'd0);
    stream(6, 0);
    stop_with_beat();
    start_run(32'd0, 32'hFFFF_FFFF, 32'd10, 1'b1, 16'd0);
    stream(6, 0);
    stop_with_beat();
    start_run(32'hFFFF_FFF0, 32'd8, 32'hFFFF_FFFF, 1'b0, 16'd0);
    stream(6, 0);
    stop_with_beat();
    start_run(32'hFFFF_FFF0, 32'd8, 32'hFFFF_FFFF, 1'b1, 16'd0);
    stream(10, 0);
    stop_with_beat();
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      start_run(32'($urandom_range(50)), 32'($urandom_range(20)),
                32'($urandom_range(100)), 1'($urandom_range(1)),
                16'($urandom_range(5)));
      stream(25, 30);
      stop_with_beat();
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; tready = 1'b0;
    start = '0; inc = '0; limit = '0; len = '0;
    bidx = 0; cur_len = '0;
    do_reset();
    test_reset();
    test_sawtooth();
    test_triangle();
    test_backpressure();
    test_frames();
    test_drain();
    test_reset_midrun();
    test_edges();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
